// File: rtl/flappy_score_pkg.sv
// Shared definitions for the flappy-bird score keeper: FSM encoding,
// score ceiling and the default OVER-state display alternation period.
package flappy_score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam int SCORE_MAX          = 255;
    localparam int ALT_CYCLES_DEFAULT = 100000000;

endpackage

// File: rtl/score_keeper_rise_detect.sv
// Single-input rising-edge detector. History resets high so a level that is
// already asserted when reset releases never reports an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulse = in & ~hist_q;

endmodule

// File: rtl/score_keeper.sv
// Round/score/high-score tracker for the flappy-bird game. Every output is a
// flop; score_out is computed from next-state values so it tracks the FSM.
module score_keeper
    import flappy_score_pkg::*;
#(
    parameter int ALT_CYCLES = ALT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pipe_pass,
    input  logic       crash,
    output logic [7:0] score_out,
    output logic [7:0] score,
    output logic [7:0] best,
    output logic       new_best,
    output logic [1:0] state
);

    localparam int             CNT_W    = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_CYCLES - 1);
    localparam logic [7:0]     SCORE_TOP = 8'(SCORE_MAX);

    logic start_pulse;
    logic pipe_pulse;
    logic crash_pulse;

    state_e           state_q, state_d;
    logic [7:0]       score_q, score_d;
    logic [7:0]       best_q, best_d;
    logic [7:0]       score_out_q, score_out_d;
    logic             new_best_q, new_best_d;
    logic [CNT_W-1:0] alt_cnt_q, alt_cnt_d;
    logic             show_best_q, show_best_d;

    rise_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (start),
        .pulse (start_pulse)
    );

    rise_detect u_pipe_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (pipe_pass),
        .pulse (pipe_pulse)
    );

    rise_detect u_crash_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (crash),
        .pulse (crash_pulse)
    );

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        best_d      = best_q;
        new_best_d  = new_best_q;
        alt_cnt_d   = alt_cnt_q;
        show_best_d = show_best_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d    = ST_PLAY;
                    score_d    = 8'd0;
                    new_best_d = 1'b0;
                end
            end
            ST_PLAY: begin
                // Crash takes priority over a point scored on the same cycle.
                if (crash_pulse) begin
                    state_d     = ST_OVER;
                    alt_cnt_d   = '0;
                    show_best_d = 1'b0;
                    if (score_q > best_q) begin
                        best_d     = score_q;
                        new_best_d = 1'b1;
                    end
                end else if (pipe_pulse && (score_q != SCORE_TOP)) begin
                    score_d = score_q + 8'd1;
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    state_d    = ST_PLAY;
                    score_d    = 8'd0;
                    new_best_d = 1'b0;
                end else if (alt_cnt_q == CNT_LAST) begin
                    alt_cnt_d   = '0;
                    show_best_d = ~show_best_q;
                end else begin
                    alt_cnt_d = alt_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_PLAY: score_out_d = score_d;
            ST_OVER: score_out_d = show_best_d ? best_d : score_d;
            default: score_out_d = best_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            score_q     <= 8'd0;
            best_q      <= 8'd0;
            new_best_q  <= 1'b0;
            score_out_q <= 8'd0;
            alt_cnt_q   <= '0;
            show_best_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            score_out_q <= score_out_d;
            alt_cnt_q   <= alt_cnt_d;
            show_best_q <= show_best_d;
        end
    end

    assign score_out = score_out_q;
    assign score     = score_q;
    assign best      = best_q;
    assign new_best  = new_best_q;
    assign state     = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed vector table, randomized
// traffic against a round-level reference model, and hand-written corner cases.
module tb_score_keeper;

    localparam int ALT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       pipe_pass;
    logic       crash;
    logic [7:0] score_out;
    logic [7:0] score;
    logic [7:0] best;
    logic       new_best;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: game state as plain integers, OVER display phase derived
    // from the number of cycles spent in OVER.
    int m_state;
    int m_score;
    int m_best;
    int m_new_best;
    int m_age;
    int m_prev_s;
    int m_prev_p;
    int m_prev_c;

    typedef struct {
        logic s;
        logic p;
        logic c;
        int   exp_state;
        int   exp_score;
        int   exp_out;
    } vec_t;

    vec_t tbl[$];

    score_keeper #(.ALT_CYCLES(ALT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pipe_pass (pipe_pass),
        .crash     (crash),
        .score_out (score_out),
        .score     (score),
        .best      (best),
        .new_best  (new_best),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic p, input logic c,
                                input int st, input int sc, input int so);
        vec_t v;
        v.s = s; v.p = p; v.c = c;
        v.exp_state = st; v.exp_score = sc; v.exp_out = so;
        return v;
    endfunction

    function void model_reset();
        m_state = 0; m_score = 0; m_best = 0; m_new_best = 0; m_age = 0;
        m_prev_s = 1; m_prev_p = 1; m_prev_c = 1;
    endfunction

    function void model_clock(input int s, input int p, input int c);
        int es, ep, ec;
        es = (s == 1 && m_prev_s == 0) ? 1 : 0;
        ep = (p == 1 && m_prev_p == 0) ? 1 : 0;
        ec = (c == 1 && m_prev_c == 0) ? 1 : 0;
        m_prev_s = s; m_prev_p = p; m_prev_c = c;
        if (m_state == 0) begin
            if (es == 1) begin m_state = 1; m_score = 0; m_new_best = 0; end
        end else if (m_state == 1) begin
            if (ec == 1) begin
                m_state = 2; m_age = 0;
                if (m_score > m_best) begin m_best = m_score; m_new_best = 1; end
            end else if (ep == 1 && m_score < 255) begin
                m_score = m_score + 1;
            end
        end else begin
            if (es == 1) begin m_state = 1; m_score = 0; m_new_best = 0; end
            else m_age = m_age + 1;
        end
    endfunction

    function int model_out();
        if (m_state == 0) return m_best;
        if (m_state == 1) return m_score;
        return (((m_age / ALT) % 2) == 1) ? m_best : m_score;
    endfunction

    task automatic check_value(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name);
        check_value({name, ".state"},     int'(state),     m_state);
        check_value({name, ".score"},     int'(score),     m_score);
        check_value({name, ".best"},      int'(best),      m_best);
        check_value({name, ".new_best"},  int'(new_best),  m_new_best);
        check_value({name, ".score_out"}, int'(score_out), model_out());
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic c);
        start = s; pipe_pass = p; crash = c;
        @(posedge clk);
        model_clock(int'(s), int'(p), int'(c));
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_value("reset.state", int'(state), 0);
        check_value("reset.score", int'(score), 0);
        check_value("reset.best", int'(best), 0);
        check_value("reset.new_best", int'(new_best), 0);
        check_value("reset.score_out", int'(score_out), 0);
        rst_n = 1'b1;
    endtask

    task automatic score_pipes(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput(name);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_round();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int seq36[9];
        start = 1'b0; pipe_pass = 1'b0; crash = 1'b0;

        // Directed table: held pipe_pass counts once, then a round ends and restarts.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 3; k++) begin
            for (int h = 0; h < 5; h++) tbl.push_back(mk(0, 1, 0, 1, k, k));
            tbl.push_back(mk(0, 0, 0, 1, k, k));
        end
        tbl.push_back(mk(0, 0, 1, 2, 3, 3));
        for (int h = 0; h < 7; h++) tbl.push_back(mk(0, 0, 0, 2, 3, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s, tbl[i].p, tbl[i].c);
            check_value($sformatf("tbl%0d.state", i), int'(state), tbl[i].exp_state);
            check_value($sformatf("tbl%0d.score", i), int'(score), tbl[i].exp_score);
            check_value($sformatf("tbl%0d.score_out", i), int'(score_out), tbl[i].exp_out);
            checkOutput($sformatf("tbl%0d", i));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(logic'($urandom_range(0, 11) == 0),
                          logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 24) == 0));
            checkOutput($sformatf("rand%0d", i));
        end

        // Saturation at 255.
        start = 1'b0; pipe_pass = 1'b0; crash = 1'b0;
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(254, "sat_fill");
        check_value("sat.score254", int'(score), 254);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            check_value($sformatf("sat.edge%0d", i), int'(score), 255);
            checkOutput("sat");
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        check_value("sat.best", int'(best), 255);
        check_value("sat.new_best", int'(new_best), 1);

        // Crash and pipe_pass together at score 7 with best 5.
        applyStimulus(1'b0, 1'b0, 1'b0);
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(5, "r35a");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(7, "r35b");
        applyStimulus(1'b0, 1'b1, 1'b1);
        check_value("r35.state", int'(state), 2);
        check_value("r35.score", int'(score), 7);
        check_value("r35.best", int'(best), 7);
        check_value("r35.new_best", int'(new_best), 1);
        check_value("r35.out0", int'(score_out), 7);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            check_value($sformatf("r35.out%0d", i), int'(score_out), 7);
        end

        // Lower score than best: no new best, display alternates score/best.
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(9, "r36a");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(4, "r36b");
        seq36 = '{4, 4, 4, 4, 9, 9, 9, 9, 4};
        applyStimulus(1'b0, 1'b0, 1'b1);
        check_value("r36.best", int'(best), 9);
        check_value("r36.new_best", int'(new_best), 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) applyStimulus(1'b0, 1'b0, 1'b0);
            check_value($sformatf("r36.out%0d", i), int'(score_out), seq36[i]);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        check_value("r36.restart.state", int'(state), 1);
        check_value("r36.restart.score", int'(score), 0);
        check_value("r36.restart.best", int'(best), 9);
        applyStimulus(1'b0, 1'b1, 1'b0);
        check_value("r36.held_pipe", int'(score), 0);

        // Inputs held high through reset release produce no edge.
        start = 1'b1; pipe_pass = 1'b1; crash = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            check_value($sformatf("r37.idle%0d", i), int'(state), 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        check_value("r37.play", int'(state), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            check_value($sformatf("r37.noinc%0d", i), int'(score), 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        check_value("r37.inc", int'(score), 1);
        checkOutput("r37");

        // Asynchronous reset mid-round, checked between clock edges.
        applyStimulus(1'b0, 1'b0, 1'b0);
        do_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        start_round();
        score_pipes(12, "r38");
        check_value("r38.score12", int'(score), 12);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_value("r38.async.state", int'(state), 0);
        check_value("r38.async.score", int'(score), 0);
        check_value("r38.async.best", int'(best), 0);
        check_value("r38.async.new_best", int'(new_best), 0);
        check_value("r38.async.score_out", int'(score_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("r38.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
